// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the memory_burst block: FSM state,
// byte-lane arithmetic and the depth/address-width legality check.
package mem_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   function automatic int lane_count(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int index_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic bit depth_ok(input int depth, input int addr_width);
      return (depth >= 1) && (longint'(depth) <= (longint'(1) << addr_width));
   endfunction

endpackage

// File: rtl/memory_burst_if.sv
// CPU-side bus of memory_burst: control unit drives the master side, the
// memory block sits on the slave side.
interface memory_burst_if
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int BURST_W    = 8
);
   logic                              addr_en;
   logic [ADDR_WIDTH-1:0]             addr;
   logic                              inc_en;
   logic                              in_en;
   logic [lane_count(DATA_WIDTH)-1:0] be;
   logic [DATA_WIDTH-1:0]             in;
   logic                              out_en;
   logic                              burst_start;
   logic [BURST_W-1:0]                burst_len;
   logic [DATA_WIDTH-1:0]             out;
   logic                              out_valid;
   logic                              busy;
   logic                              err;

   modport master (
      output addr_en, addr, inc_en, in_en, be, in, out_en, burst_start, burst_len,
      input  out, out_valid, busy, err
   );

   modport slave (
      input  addr_en, addr, inc_en, in_en, be, in, out_en, burst_start, burst_len,
      output out, out_valid, busy, err
   );
endinterface

// File: rtl/mem_array.sv
// Word storage with byte-lane writes. Read is combinational so the owner's
// output register samples the pre-write contents on the same edge.
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 65536,
   parameter int IDX_W      = 16
) (
   input  logic                              clk,
   input  logic                              we,
   input  logic [lane_count(DATA_WIDTH)-1:0] be,
   input  logic [IDX_W-1:0]                  idx,
   input  logic [DATA_WIDTH-1:0]             wdata,
   output logic [DATA_WIDTH-1:0]             rdata
);
   localparam int LANES = lane_count(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

   assign rdata = mem_r[idx];

   // Byte-lane write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we && be[i]) begin
            mem_r[idx][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end
endmodule

// File: rtl/memory_burst.sv
// Single-port word memory with internal MAR, post-increment, sticky
// out-of-range error and a sequential burst-read engine.
module memory_burst
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 65536,
   parameter int BURST_W    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   memory_burst_if.slave bus
);
   localparam int                    IDX_W       = index_width(DEPTH);
   localparam int                    AW1         = ADDR_WIDTH + 1;
   localparam bit                    DEPTH_LEGAL = depth_ok(DEPTH, ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = AW1'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1'b1);
   localparam logic [BURST_W-1:0]    CNT_ONE     = BURST_W'(1'b1);

   state_t                  state_r, state_s;
   logic [BURST_W-1:0]      count_r, count_s;
   logic [ADDR_WIDTH-1:0]   mar_r, mar_s, mar_inc_s;
   logic                    rd_s, wr_s, in_range_s, mem_we_s;
   logic [DATA_WIDTH-1:0]   rdata_s, out_r;
   logic                    out_valid_r, busy_r, err_r;

   assign mar_inc_s  = (mar_r == LAST_ADDR) ? {ADDR_WIDTH{1'b0}} : mar_r + ADDR_ONE;
   // An illegal DEPTH makes every access out-of-range rather than aliasing
   assign in_range_s = DEPTH_LEGAL && ({1'b0, mar_r} < DEPTH_EXT);
   assign mem_we_s   = wr_s & in_range_s;

   mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .be    (bus.be),
      .idx   (mar_r[IDX_W-1:0]),
      .wdata (bus.in),
      .rdata (rdata_s)
   );

   // Next-state, MAR and access decode
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      mar_s   = mar_r;
      rd_s    = 1'b0;
      wr_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.burst_start) begin
               count_s = (bus.burst_len == {BURST_W{1'b0}}) ? CNT_ONE : bus.burst_len;
               state_s = BURST;
            end else begin
               wr_s = bus.in_en;
               rd_s = bus.out_en;
               if (bus.addr_en) begin
                  mar_s = bus.addr;
               end else if (bus.inc_en && (bus.in_en || bus.out_en)) begin
                  mar_s = mar_inc_s;
               end else begin
                  mar_s = mar_r;
               end
            end
         end
         BURST: begin
            rd_s    = 1'b1;
            mar_s   = mar_inc_s;
            count_s = count_r - CNT_ONE;
            if (count_r == CNT_ONE) begin
               state_s = IDLE;
            end else begin
               state_s = BURST;
            end
         end
         default: begin
            state_s = IDLE;
            count_s = {BURST_W{1'b0}};
         end
      endcase
   end

   // FSM, burst counter and MAR registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         count_r <= {BURST_W{1'b0}};
         mar_r   <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         count_r <= count_s;
         mar_r   <= mar_s;
      end
   end

   // Registered read data and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r       <= {DATA_WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         out_valid_r <= rd_s;
         busy_r      <= (state_s == BURST);
         err_r       <= err_r | ((rd_s | wr_s) & ~in_range_s);
         if (rd_s) begin
            out_r <= in_range_s ? rdata_s : {DATA_WIDTH{1'b0}};
         end else begin
            out_r <= out_r;
         end
      end
   end

   assign bus.out       = out_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.err       = err_r;
endmodule
